mult_div_unit: RTL and testbench

Iterative signed multiply/divide unit driven by the multicycle control FSM for the R-format MULT and DIV instructions. It accepts one-cycle start pulses with operands from the A/B registers. It iterates for 32 cycles, then presents a 64-bit result on hiOut/loOut with a one-cycle done pulse, or raises div0 for a zero divisor. The HI/LO registers and their write enables stay outside this block; the control FSM loads them on done.

---
 rtl/mult_div_unit.sv | 157 +++++++++++++++
 tb/tb_mult_div_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit: radix-2 Booth multiply and restoring
// divide on magnitudes, WIDTH iterations per operation, one-cycle done/div0 pulses.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multStart,
  input  logic             divStart,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hiOut,
  output logic [WIDTH-1:0] loOut,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int AW = 2 * WIDTH + 2;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MULT_RUN, DIV_RUN, FINISH} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, div0_q, div0_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // Booth step: the upper partial product carries one guard bit so that
  // subtracting the most negative multiplicand cannot overflow.
  logic [WIDTH:0] p_hi, m_ext, p_sum;
  logic [AW-1:0]  booth_nx;
  assign p_hi  = acc_q[AW-1:WIDTH+1];
  assign m_ext = {m_q[WIDTH-1], m_q};

  always_comb begin
    unique case (acc_q[1:0])
      2'b01:   p_sum = p_hi + m_ext;
      2'b10:   p_sum = p_hi - m_ext;
      default: p_sum = p_hi;
    endcase
  end

  assign booth_nx = {p_sum[WIDTH], p_sum, acc_q[WIDTH:1]};

  // Restoring divide step on {remainder, quotient} held in acc_q[2W-1:0].
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] rem_new;
  logic [AW-1:0]    div_nx;
  assign rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
  assign trial   = rem_sh - {1'b0, m_q};
  assign rem_new = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign div_nx  = {2'b00, rem_new, acc_q[WIDTH-2:0], ~trial[WIDTH]};

  always_comb begin
    // NOTE: every variable gets a default here so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    m_d       = m_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    div0_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (multStart) begin
          m_d     = a;
          acc_d   = {{(WIDTH + 1){1'b0}}, b, 1'b0};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = MULT_RUN;
        end else if (divStart) begin
          if (b != '0) begin
            m_d       = b_mag;
            acc_d     = {{(WIDTH + 2){1'b0}}, a_mag};
            neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem_d = a[WIDTH-1];
            cnt_d     = '0;
            busy_d    = 1'b1;
            state_d   = DIV_RUN;
          end else begin
            div0_d = 1'b1;
          end
        end
      end
      MULT_RUN, DIV_RUN: begin
        acc_d = (state_q == DIV_RUN) ? div_nx : booth_nx;
        cnt_d = cnt_q + CW'(1);
        // The result is registered on the edge entering FINISH so it is
        // valid in the same cycle that done is high.
        if (cnt_q == LAST_ITER) begin
          state_d = FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (state_q == DIV_RUN) begin
            lo_d = neg_quo_q ? -div_nx[WIDTH-1:0] : div_nx[WIDTH-1:0];
            hi_d = neg_rem_q ? -div_nx[2*WIDTH-1:WIDTH] : div_nx[2*WIDTH-1:WIDTH];
          end else begin
            {hi_d, lo_d} = booth_nx[2*WIDTH:1];
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      m_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
    end
  end

  assign hiOut = hi_q;
  assign loOut = lo_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign div0  = div0_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, scoreboard queue of
// expected results, and hand-written sequences for the multi-cycle corner cases.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        multStart, divStart;
  logic [31:0] a, b;
  logic [31:0] hiOut, loOut;
  logic        busy, done, div0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .multStart(multStart), .divStart(divStart),
    .a(a), .b(b), .hiOut(hiOut), .loOut(loOut),
    .busy(busy), .done(done), .div0(div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  typedef struct {
    string       name;
    logic        is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  res_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents a start for one cycle; returns #1 after the sampling edge (cycle 1).
  task automatic pulse_start(input logic m, input logic d, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    multStart = m;
    divStart  = d;
    a         = av;
    b         = bv;
    @(posedge clk);
    #1;
    multStart = 1'b0;
    divStart  = 1'b0;
    a         = $urandom;
    b         = $urandom;
  endtask

  task automatic pop_and_check(input string name);
    res_t e;
    check({name, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({name, "_hi"}, 64'(hiOut), 64'(e.hi));
      check({name, "_lo"}, 64'(loOut), 64'(e.lo));
    end
  endtask

  // Watches cycles 1.. after a start: busy must hold until done, done at cycle 33.
  task automatic wait_done(input string name);
    res_t e;
    bit   seen = 0;
    int   bad  = 0;
    int   lat  = 0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge clk);
      if (div0) bad++;
      if (done) begin
        seen = 1;
        lat  = cyc;
        if (busy) bad++;
        pop_and_check(name);
      end else if (busy !== 1'b1) begin
        bad++;
      end
    end
    check({name, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) check({name, "_latency"}, 64'(lat), 64'd33);
    check({name, "_protocol"}, 64'(bad), 64'd0);
    if (!seen && sb_q.size() != 0) e = sb_q.pop_front();
  endtask

  task automatic run_op(input string name, input logic is_div, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el);
    sb_q.push_back('{hi: eh, lo: el});
    pulse_start(!is_div, is_div, av, bv);
    wait_done(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[10];
    int          bad;
    int          n_done;
    int          done_cyc;
    int signed   sa, sbv;
    longint      p, q, r;
    logic [31:0] ra, rb;
    bit          rdiv;

    vecs[0] = '{"mul_7_m3",      1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{"mul_min_min",   1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[2] = '{"div_m7_2",      1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{"div_100_7",     1'b1, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4] = '{"div_min_m1",    1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{"mul_m1_m1",     1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[6] = '{"mul_max_max",   1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[7] = '{"div_7_m2",      1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8] = '{"div_5_10",      1'b1, 32'd5,        32'd10,       32'd5,        32'd0};
    vecs[9] = '{"mul_min_1",     1'b0, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000};

    multStart = 1'b0;
    divStart  = 1'b0;
    a         = '0;
    b         = '0;
    reset     = 1'b1;
    #3 reset  = 1'b0;
    #1;
    check("rst_hi",   64'(hiOut), 64'd0);
    check("rst_lo",   64'(loOut), 64'd0);
    check("rst_busy", 64'(busy),  64'd0);
    check("rst_done", 64'(done),  64'd0);
    check("rst_div0", 64'(div0),  64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].is_div, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);

    // Divide by zero leaves the previous result in place and never goes busy.
    run_op("div0_prior", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
    pulse_start(1'b0, 1'b1, 32'd5, 32'd0);
    @(negedge clk);
    check("div0_pulse",     64'(div0), 64'd1);
    check("div0_busy",      64'(busy), 64'd0);
    check("div0_done",      64'(done), 64'd0);
    @(negedge clk);
    check("div0_one_cycle", 64'(div0), 64'd0);
    bad = 0;
    repeat (36) begin
      @(negedge clk);
      if (done || busy || div0) bad++;
    end
    check("div0_quiet", 64'(bad),   64'd0);
    check("div0_hi",    64'(hiOut), 64'd2);
    check("div0_lo",    64'(loOut), 64'd14);

    // A start arriving while busy is dropped: exactly one done, at cycle 33.
    sb_q.push_back('{hi: 32'd0, lo: 32'd30});
    pulse_start(1'b1, 1'b0, 32'd5, 32'd6);
    bad      = 0;
    n_done   = 0;
    done_cyc = 0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(negedge clk);
      if (div0) bad++;
      if (done) begin
        n_done++;
        done_cyc = cyc;
        if (n_done == 1) pop_and_check("busy_ign");
      end
      if (cyc == 10) begin
        divStart = 1'b1;
        a        = 32'd9;
        b        = 32'd0;
      end else if (cyc == 11) begin
        divStart = 1'b0;
      end
    end
    check("busy_ign_ndone", 64'(n_done),   64'd1);
    check("busy_ign_cyc",   64'(done_cyc), 64'd33);
    check("busy_ign_div0",  64'(bad),      64'd0);

    // Reset mid-operation clears every output at once; the next op is normal.
    pulse_start(1'b1, 1'b0, 32'h12345678, 32'h9ABCDEF0);
    repeat (14) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_hi",   64'(hiOut), 64'd0);
    check("midrst_lo",   64'(loOut), 64'd0);
    check("midrst_busy", 64'(busy),  64'd0);
    check("midrst_done", 64'(done),  64'd0);
    check("midrst_div0", 64'(div0),  64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_op("after_rst", 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'd0, 32'd30);

    // Simultaneous starts: multiply wins.
    sb_q.push_back('{hi: 32'd0, lo: 32'd12});
    pulse_start(1'b1, 1'b1, 32'd3, 32'd4);
    wait_done("both_start");

    // Random operands against a 64-bit signed reference.
    for (int i = 0; i < 8; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rdiv = i[0];
      if (rdiv && rb == 32'd0) rb = 32'd3;
      sa  = $signed(ra);
      sbv = $signed(rb);
      if (rdiv) begin
        q = longint'(sa) / longint'(sbv);
        r = longint'(sa) % longint'(sbv);
        run_op($sformatf("rnd_div%0d", i), 1'b1, ra, rb, r[31:0], q[31:0]);
      end else begin
        p = longint'(sa) * longint'(sbv);
        run_op($sformatf("rnd_mul%0d", i), 1'b0, ra, rb, p[63:32], p[31:0]);
      end
    end

    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
